// File: rtl/wb_latency_mem.sv
// ---------------------------------------------------------------------------
// wb_latency_mem
//   Pipelined Wishbone B4 slave memory with a fixed response latency, a cap on
//   outstanding requests and an optional deterministic stall pattern. Used in
//   place of the framebuffer/DDR3 slot on the secondary Wishbone bus to exercise
//   a master's pipelining, stall and abort handling.
//
//   Timing: a request accepted at clock edge N is answered (ack_o or err_o) in
//   the cycle ending at edge N+LATENCY, i.e. the response is driven by the flop
//   updated at edge N+LATENCY-1. Responses are in order, one per cycle.
//
// Ports
//   clk_i     in   1             clock
//   reset_i   in   1             async reset, active-high
//   cyc_i     in   1             bus cycle; dropping it aborts all pending responses
//   stb_i     in   1             request strobe
//   we_i      in   1             1 = write
//   addr_i    in   ADDR_WIDTH    word address
//   sel_i     in   DATA_WIDTH/8  byte enables
//   wdata_i   in   DATA_WIDTH    write data
//   rdata_o   out  DATA_WIDTH    read data, valid with ack_o, 0 otherwise
//   ack_o     out  1             normal termination
//   err_o     out  1             error termination (address out of range)
//   rty_o     out  1             tied 0
//   stall_o   out  1             slave cannot accept this cycle
// ---------------------------------------------------------------------------
module wb_latency_mem #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 24,
    parameter int unsigned SIZE_POT_WORDS = 16,
    parameter int unsigned LATENCY        = 4,
    parameter int unsigned MAX_OUT        = 8,
    parameter int unsigned STALL_EVERY    = 0,
    parameter string       MEMFILE        = ""
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      cyc_i,
    input  logic                      stb_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH/8-1:0]   sel_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      ack_o,
    output logic                      err_o,
    output logic                      rty_o,
    output logic                      stall_o
);

    localparam int unsigned SEL_W   = DATA_WIDTH / 8;
    localparam int unsigned DEPTH   = 2 ** SIZE_POT_WORDS;
    localparam int unsigned OUT_W   = $clog2(MAX_OUT + 1);
    // Keep the pattern counter at least one bit wide even when the pattern is off.
    localparam int unsigned STALL_N = (STALL_EVERY == 0) ? 1 : STALL_EVERY;
    localparam int unsigned CNT_W   = $clog2(STALL_N + 1);

    // One response pipeline stage.
    typedef struct packed {
        logic                  valid;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    resp_t                     pipe_q [LATENCY];
    resp_t                     pipe_d [LATENCY];
    logic [OUT_W-1:0]          outstanding_q;
    logic [OUT_W-1:0]          outstanding_d;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;
    logic                      stall_q;
    logic                      stall_d;

    logic                      accept_c;
    logic                      in_range_c;
    logic                      resp_c;
    logic                      pattern_stall_c;
    logic [SIZE_POT_WORDS-1:0] word_addr_c;

    // Request decode.
    assign accept_c    = cyc_i & stb_i & ~stall_q;
    assign in_range_c  = (addr_i >> SIZE_POT_WORDS) == '0;
    assign word_addr_c = SIZE_POT_WORDS'(addr_i);
    assign resp_c      = pipe_q[LATENCY-1].valid;

    // Byte-masked write, committed on the accepting edge; never reset.
    always_ff @(posedge clk_i) begin
        if (accept_c && we_i && in_range_c) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (sel_i[b]) begin
                    mem[word_addr_c][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Next-state: response pipeline, outstanding count, stall pattern, stall.
    always_comb begin
        for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i] = '0;
        end
        outstanding_d   = outstanding_q;
        stall_cnt_d     = stall_cnt_q;
        pattern_stall_c = 1'b0;

        if (cyc_i) begin
            if (accept_c) begin
                pipe_d[0].valid = 1'b1;
                pipe_d[0].err   = ~in_range_c;
                // Read data is captured at accept; writes and errors carry zero.
                if (!we_i && in_range_c) begin
                    pipe_d[0].data = mem[word_addr_c];
                end
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            outstanding_d = outstanding_q + OUT_W'(accept_c) - OUT_W'(resp_c);
        end else begin
            // Abort: every pending response is dropped, including the one
            // that would have appeared in the next cycle.
            outstanding_d = '0;
        end

        // Pattern counter survives aborts; only accepts advance it.
        if ((STALL_EVERY != 0) && accept_c) begin
            if (stall_cnt_q == CNT_W'(STALL_N - 1)) begin
                stall_cnt_d     = '0;
                pattern_stall_c = 1'b1;
            end else begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end

        stall_d = (outstanding_d == OUT_W'(MAX_OUT)) | pattern_stall_c;
    end

    // State registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            outstanding_q <= '0;
            stall_cnt_q   <= '0;
            stall_q       <= 1'b0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            outstanding_q <= outstanding_d;
            stall_cnt_q   <= stall_cnt_d;
            stall_q       <= stall_d;
        end
    end

    // Outputs come straight from the last pipeline flop.
    assign ack_o   = pipe_q[LATENCY-1].valid & ~pipe_q[LATENCY-1].err;
    assign err_o   = pipe_q[LATENCY-1].valid &  pipe_q[LATENCY-1].err;
    assign rdata_o = pipe_q[LATENCY-1].valid ? pipe_q[LATENCY-1].data : '0;
    assign rty_o   = 1'b0;
    assign stall_o = stall_q;

endmodule

// File: tb/tb_wb_latency_mem.sv
// ---------------------------------------------------------------------------
// tb_wb_latency_mem
//   Three instances: A (defaults, LATENCY=4) checked by a scoreboard fed from a
//   vector table, B (MAX_OUT=2) and C (STALL_EVERY=3) checked against
//   hand-derived per-cycle stall/ack patterns.
// ---------------------------------------------------------------------------
module tb_wb_latency_mem;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 24;
    localparam int unsigned SW  = 4;
    localparam int unsigned LAT = 4;

    logic clk;
    logic rst;

    logic          a_cyc, a_stb, a_we, a_ack, a_err, a_rty, a_stall;
    logic [AW-1:0] a_addr;
    logic [SW-1:0] a_sel;
    logic [DW-1:0] a_wdata, a_rdata;

    logic          b_cyc, b_stb, b_we, b_ack, b_err, b_rty, b_stall;
    logic [AW-1:0] b_addr;
    logic [SW-1:0] b_sel;
    logic [DW-1:0] b_wdata, b_rdata;

    logic          c_cyc, c_stb, c_we, c_ack, c_err, c_rty, c_stall;
    logic [AW-1:0] c_addr;
    logic [SW-1:0] c_sel;
    logic [DW-1:0] c_wdata, c_rdata;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        int unsigned   cyc;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        tbl[14];
    vec_t        v;
    int unsigned n_vec     = 0;
    int unsigned n_miss    = 0;
    int unsigned cyc_cnt   = 0;
    int unsigned resp_seen = 0;
    int unsigned b_acc     = 0;
    int unsigned b_ack_cnt = 0;
    int unsigned c_acc     = 0;
    int unsigned c_ack_cnt = 0;
    int unsigned snap;
    logic [0:11] b_stall_exp;
    logic [0:11] b_ack_exp;

    wb_latency_mem #(.LATENCY(LAT)) u_dut_a (
        .clk_i(clk), .reset_i(rst), .cyc_i(a_cyc), .stb_i(a_stb), .we_i(a_we),
        .addr_i(a_addr), .sel_i(a_sel), .wdata_i(a_wdata), .rdata_o(a_rdata),
        .ack_o(a_ack), .err_o(a_err), .rty_o(a_rty), .stall_o(a_stall)
    );

    wb_latency_mem #(.SIZE_POT_WORDS(8), .LATENCY(LAT), .MAX_OUT(2)) u_dut_b (
        .clk_i(clk), .reset_i(rst), .cyc_i(b_cyc), .stb_i(b_stb), .we_i(b_we),
        .addr_i(b_addr), .sel_i(b_sel), .wdata_i(b_wdata), .rdata_o(b_rdata),
        .ack_o(b_ack), .err_o(b_err), .rty_o(b_rty), .stall_o(b_stall)
    );

    wb_latency_mem #(.SIZE_POT_WORDS(8), .LATENCY(LAT), .STALL_EVERY(3)) u_dut_c (
        .clk_i(clk), .reset_i(rst), .cyc_i(c_cyc), .stb_i(c_stb), .we_i(c_we),
        .addr_i(c_addr), .sel_i(c_sel), .wdata_i(c_wdata), .rdata_o(c_rdata),
        .ack_o(c_ack), .err_o(c_err), .rty_o(c_rty), .stall_o(c_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edge counter and accept counters, sampled at the active edge.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (b_cyc && b_stb && !b_stall) b_acc <= b_acc + 1;
        if (c_cyc && c_stb && !c_stall) c_acc <= c_acc + 1;
    end

    // Scoreboard monitor for instance A, plus ack counters for B and C.
    always @(negedge clk) begin : mon
        exp_t e;
        if (b_ack) b_ack_cnt++;
        if (c_ack) c_ack_cnt++;
        if (a_ack || a_err) begin
            resp_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 64'({a_ack, a_err}), 64'(0));
            end else begin
                e = sb_q.pop_front();
                check("resp_cycle", 64'(cyc_cnt), 64'(e.cyc));
                check("resp_ack",   64'(a_ack),   64'(!e.err));
                check("resp_err",   64'(a_err),   64'(e.err));
                check("resp_rdata", 64'(a_rdata), 64'(e.data));
            end
        end else if (!rst) begin
            check("idle_rdata", 64'(a_rdata), 64'(0));
        end
    end

    // Drive one request on A from a negedge; push its expectation on accept.
    task automatic issue(input vec_t vi, input bit expect_resp);
        int unsigned tries = 0;
        exp_t        e;
        a_cyc   = 1'b1;
        a_stb   = 1'b1;
        a_we    = vi.we;
        a_addr  = vi.addr;
        a_sel   = vi.sel;
        a_wdata = vi.wdata;
        while (a_stall && tries < 16) begin
            @(negedge clk);
            tries++;
        end
        if (a_stall) begin
            check("accept_timeout", 64'(a_stall), 64'(0));
        end else if (expect_resp) begin
            e.cyc  = cyc_cnt + LAT;
            e.err  = vi.exp_err;
            e.data = vi.exp_rdata;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle_a(input int unsigned n);
        a_stb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic vec_t rd(input logic [AW-1:0] addr, input logic err, input logic [DW-1:0] data);
        vec_t r;
        r = '{1'b0, addr, 4'hF, 32'h0, err, data};
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        {a_cyc, a_stb, a_we, a_addr, a_sel, a_wdata} = '0;
        {b_cyc, b_stb, b_we, b_addr, b_sel, b_wdata} = '0;
        {c_cyc, c_stb, c_we, c_addr, c_sel, c_wdata} = '0;

        tbl[0]  = '{1'b1, 24'h000010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b0, 24'h000010, 4'hF, 32'h00000000, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 24'h000020, 4'hF, 32'h11223344, 1'b0, 32'h00000000};
        tbl[3]  = '{1'b1, 24'h000020, 4'h5, 32'hAABBCCDD, 1'b0, 32'h00000000};
        tbl[4]  = '{1'b0, 24'h000020, 4'hF, 32'h00000000, 1'b0, 32'h11BB33DD};
        tbl[5]  = '{1'b1, 24'h000000, 4'hF, 32'h01020304, 1'b0, 32'h00000000};
        tbl[6]  = '{1'b0, 24'h010000, 4'hF, 32'h00000000, 1'b1, 32'h00000000};
        tbl[7]  = '{1'b1, 24'h010000, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h00000000};
        tbl[8]  = '{1'b0, 24'h000000, 4'hF, 32'h00000000, 1'b0, 32'h01020304};
        tbl[9]  = '{1'b1, 24'h00FFFF, 4'hF, 32'hCAFEF00D, 1'b0, 32'h00000000};
        tbl[10] = '{1'b0, 24'h00FFFF, 4'hF, 32'h00000000, 1'b0, 32'hCAFEF00D};
        tbl[11] = '{1'b1, 24'h000020, 4'hA, 32'h99887766, 1'b0, 32'h00000000};
        tbl[12] = '{1'b0, 24'h000020, 4'hF, 32'h00000000, 1'b0, 32'h99BB77DD};
        tbl[13] = '{1'b0, 24'hFFFFFF, 4'hF, 32'h00000000, 1'b1, 32'h00000000};

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ack",   64'(a_ack),   64'(0));
        check("rst_err",   64'(a_err),   64'(0));
        check("rst_rty",   64'(a_rty),   64'(0));
        check("rst_rdata", 64'(a_rdata), 64'(0));
        check("rst_stall", 64'(a_stall), 64'(0));
        check("rst_b_stall", 64'(b_stall), 64'(0));
        check("rst_c_stall", 64'(c_stall), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back vector stream on A.
        for (int i = 0; i < 14; i++) begin
            issue(tbl[i], 1'b1);
        end
        idle_a(LAT + 4);
        check("table_drained", 64'(sb_q.size()), 64'(0));

        // Abort: three reads accepted, cyc dropped just before the first ack.
        snap = resp_seen;
        v = rd(24'h000010, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) issue(v, 1'b0);
        a_cyc = 1'b0;
        a_stb = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        check("abort_no_resp", 64'(resp_seen - snap), 64'(0));
        check("abort_stall",   64'(a_stall), 64'(0));
        a_cyc = 1'b1;
        issue(rd(24'h000020, 1'b0, 32'h99BB77DD), 1'b1);
        idle_a(LAT + 2);
        check("post_abort_drained", 64'(sb_q.size()), 64'(0));

        // Reset mid-burst: first response arrives, the rest are discarded.
        issue(rd(24'h000010, 1'b0, 32'hDEADBEEF), 1'b1);
        issue(rd(24'h000020, 1'b0, 32'h0), 1'b0);
        issue(rd(24'h000000, 1'b0, 32'h0), 1'b0);
        a_stb = 1'b0;
        @(negedge clk);
        #2;
        snap = resp_seen;
        rst = 1'b1;
        #1;
        check("midrst_ack",   64'(a_ack),   64'(0));
        check("midrst_err",   64'(a_err),   64'(0));
        check("midrst_rdata", 64'(a_rdata), 64'(0));
        check("midrst_stall", 64'(a_stall), 64'(0));
        check("midrst_first_seen", 64'(sb_q.size()), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("midrst_no_resp", 64'(resp_seen - snap), 64'(0));
        // Memory survives reset.
        issue(rd(24'h000010, 1'b0, 32'hDEADBEEF), 1'b1);
        issue(rd(24'h00FFFF, 1'b0, 32'hCAFEF00D), 1'b1);
        idle_a(LAT + 2);
        check("post_rst_drained", 64'(sb_q.size()), 64'(0));

        // B: MAX_OUT=2, continuous writes, expected stall/ack per edge.
        b_stall_exp = 12'b011100111001;
        b_ack_exp   = 12'b000110001100;
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_sel = 4'hF; b_wdata = 32'h12345678;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("b_stall_e%0d", k), 64'(b_stall), 64'(b_stall_exp[k-1]));
            check($sformatf("b_ack_e%0d", k),   64'(b_ack),   64'(b_ack_exp[k-1]));
        end
        b_stb = 1'b0;
        repeat (8) @(negedge clk);
        check("b_accepts", 64'(b_acc),     64'(6));
        check("b_acks",    64'(b_ack_cnt), 64'(6));

        // B abort with the cap reached: outstanding must return to zero.
        b_stb = 1'b1;
        repeat (2) @(negedge clk);
        check("b_cap_stall", 64'(b_stall), 64'(1));
        b_cyc = 1'b0;
        b_stb = 1'b0;
        @(negedge clk);
        check("b_abort_stall", 64'(b_stall), 64'(0));
        snap  = b_ack_cnt;
        b_cyc = 1'b1;
        b_stb = 1'b1;
        @(negedge clk);
        b_stb = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("b_abort_acks", 64'(b_ack_cnt - snap), 64'(1));
        check("b_abort_accepts", 64'(b_acc), 64'(9));

        // C: STALL_EVERY=3, stall after every 3rd accept.
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b1; c_sel = 4'hF; c_wdata = 32'h0BADF00D;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("c_stall_e%0d", k), 64'(c_stall), 64'((k % 4) == 3));
        end
        c_stb = 1'b0;
        repeat (8) @(negedge clk);
        check("c_accepts", 64'(c_acc),     64'(15));
        check("c_acks",    64'(c_ack_cnt), 64'(15));

        check("b_err_final",   64'(b_err),   64'(0));
        check("b_rty_final",   64'(b_rty),   64'(0));
        check("b_rdata_final", 64'(b_rdata), 64'(0));
        check("c_err_final",   64'(c_err),   64'(0));
        check("c_rty_final",   64'(c_rty),   64'(0));
        check("c_rdata_final", 64'(c_rdata), 64'(0));
        check("sb_final_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
